// File: rtl/nco_pkg.sv
// Shared NCO definitions: default tuning-word and dwell widths, plus the
// sweep controller state encoding.
package nco_pkg;

  // Default widths reused by NCO and sweep controller instantiations.
  localparam int unsigned NCO_ACC_SIZE   = 16;
  localparam int unsigned NCO_DWELL_SIZE = 16;

  typedef enum logic [1:0] {
    SWEEP_IDLE = 2'd0,
    SWEEP_RUN  = 2'd1,
    SWEEP_DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell timer for the sweep controller: a load/decrement down-counter with a
// registered expired flag that is high while the count is zero.
//
// Ports:
//   clock      - sole clock
//   reset      - asynchronous active-high reset (count cleared, expired set)
//   load       - load load_value (priority over enable)
//   enable     - decrement while the count is non-zero
//   load_value - value loaded on load
//   expired    - registered, high when the count is zero
module nco_dwell_timer
  import nco_pkg::*;
#(
  parameter int unsigned DWELL_SIZE = NCO_DWELL_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  enable,
  input  logic [DWELL_SIZE-1:0] load_value,
  output logic                  expired
);

  logic [DWELL_SIZE-1:0] count;

  // expired is tracked alongside count so it never depends on a wide compare
  // of the live counter value in the same cycle it is consumed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b1;
    end else if (load) begin
      count   <= load_value;
      expired <= (load_value == '0);
    end else if (enable && !expired) begin
      count   <= count - DWELL_SIZE'(1);
      expired <= (count == DWELL_SIZE'(1));
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer driving the NCO tuning word. On start it latches
// start/stop/step/dwell, steps the tuning word linearly from start toward stop
// (clamped at stop, never wrapping), holds each word for dwell+1 clocks and
// pulses done for one cycle at the end.
//
// Optional build macro: NCO_SWEEP_LOOP_EN adds input 'loop'; when high at the
// expiry of the stop word, done pulses while the sweep restarts from the
// latched start word instead of finishing.
//
// Ports:
//   clock       - sole clock, rising edge
//   reset       - asynchronous active-high reset
//   start       - sweep request, sampled only in IDLE
//   abort       - terminates a sweep in progress (highest priority)
//   start_word  - first tuning word
//   stop_word   - final tuning word
//   step_word   - increment magnitude
//   dwell       - each word is held dwell+1 cycles
//   tuning_word - registered tuning word to the NCO
//   busy        - registered, high while sweeping
//   done        - registered one-cycle completion pulse
//   loop        - (NCO_SWEEP_LOOP_EN only) repeat sweep at end
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned ACC_SIZE   = NCO_ACC_SIZE,
  parameter int unsigned DWELL_SIZE = NCO_DWELL_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ACC_SIZE-1:0]   start_word,
  input  logic [ACC_SIZE-1:0]   stop_word,
  input  logic [ACC_SIZE-1:0]   step_word,
  input  logic [DWELL_SIZE-1:0] dwell,
  output logic [ACC_SIZE-1:0]   tuning_word,
  output logic                  busy,
  output logic                  done
`ifdef NCO_SWEEP_LOOP_EN
  ,
  input  logic                  loop
`endif
);

  sweep_state_t          state;

  logic [ACC_SIZE-1:0]   cfg_start;
  logic [ACC_SIZE-1:0]   cfg_stop;
  logic [ACC_SIZE-1:0]   cfg_step;
  logic [DWELL_SIZE-1:0] cfg_dwell;
  logic                  cfg_up;

  logic                  loop_c;
  logic                  at_stop_c;
  logic                  timer_expired;
  logic                  timer_load_c;
  logic                  timer_en_c;
  logic [DWELL_SIZE-1:0] timer_value_c;

  logic [ACC_SIZE:0]     sum_c;
  logic [ACC_SIZE:0]     diff_c;
  logic [ACC_SIZE-1:0]   next_word_c;

`ifdef NCO_SWEEP_LOOP_EN
  assign loop_c = loop;
`else
  assign loop_c = 1'b0;
`endif

  assign at_stop_c = (tuning_word == cfg_stop);

  // Step arithmetic in ACC_SIZE+1 bits: the extra bit catches both overflow
  // past the top of the range and underflow below zero, so the word clamps
  // to stop instead of wrapping.
  assign sum_c  = {1'b0, tuning_word} + {1'b0, cfg_step};
  assign diff_c = {1'b0, tuning_word} - {1'b0, cfg_step};

  // Next word, clamped at stop; a zero step jumps directly to stop.
  always_comb begin
    next_word_c = cfg_stop;
    if (cfg_step != '0) begin
      if (cfg_up) begin
        if (sum_c < {1'b0, cfg_stop}) begin
          next_word_c = sum_c[ACC_SIZE-1:0];
        end
      end else begin
        if (!diff_c[ACC_SIZE] && (diff_c[ACC_SIZE-1:0] > cfg_stop)) begin
          next_word_c = diff_c[ACC_SIZE-1:0];
        end
      end
    end
  end

  // Dwell timer control: load on sweep start and on every word change
  // (including a loop restart), otherwise count down while sweeping.
  always_comb begin
    timer_load_c  = 1'b0;
    timer_en_c    = 1'b0;
    timer_value_c = cfg_dwell;
    case (state)
      SWEEP_IDLE: begin
        if (start && !abort) begin
          timer_load_c  = 1'b1;
          timer_value_c = dwell;
        end
      end
      SWEEP_RUN: begin
        if (!abort) begin
          if (timer_expired) begin
            timer_load_c = !at_stop_c || loop_c;
          end else begin
            timer_en_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  nco_dwell_timer #(
    .DWELL_SIZE (DWELL_SIZE)
  ) u_dwell_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load_c),
    .enable     (timer_en_c),
    .load_value (timer_value_c),
    .expired    (timer_expired)
  );

  // Sweep state machine with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SWEEP_IDLE;
      tuning_word <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_start   <= '0;
      cfg_stop    <= '0;
      cfg_step    <= '0;
      cfg_dwell   <= '0;
      cfg_up      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SWEEP_IDLE: begin
          if (start && !abort) begin
            cfg_start   <= start_word;
            cfg_stop    <= stop_word;
            cfg_step    <= step_word;
            cfg_dwell   <= dwell;
            cfg_up      <= (stop_word >= start_word);
            tuning_word <= start_word;
            busy        <= 1'b1;
            state       <= SWEEP_RUN;
          end
        end
        SWEEP_RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= SWEEP_IDLE;
          end else if (timer_expired) begin
            if (!at_stop_c) begin
              tuning_word <= next_word_c;
            end else if (loop_c) begin
              // Completion is reported but the sweep restarts immediately.
              tuning_word <= cfg_start;
              done        <= 1'b1;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= SWEEP_DONE;
            end
          end
        end
        SWEEP_DONE: begin
          state <= SWEEP_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= SWEEP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: expected per-cycle outputs are
// queued when a sweep is launched and compared every falling edge.
module tb_nco_sweep_ctrl;

  typedef struct packed {
    logic [15:0] tw;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] start_word;
  logic [15:0] stop_word;
  logic [15:0] step_word;
  logic [15:0] dwell;
  logic [15:0] tuning_word;
  logic        busy;
  logic        done;
`ifdef NCO_SWEEP_LOOP_EN
  logic        loop;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  nco_sweep_ctrl #(
    .ACC_SIZE   (16),
    .DWELL_SIZE (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .start_word  (start_word),
    .stop_word   (stop_word),
    .step_word   (step_word),
    .dwell       (dwell),
    .tuning_word (tuning_word),
    .busy        (busy),
    .done        (done)
`ifdef NCO_SWEEP_LOOP_EN
    ,
    .loop        (loop)
`endif
  );

  always #5 clock = ~clock;

  task automatic push_exp(input int tw, input logic b, input logic d);
    exp_t e;
    e.tw   = 16'(tw);
    e.busy = b;
    e.done = d;
    sb.push_back(e);
  endtask

  // Reference sweep model in unbounded integer arithmetic.
  task automatic push_sweep(input int s, input int e, input int st, input int dw,
                            output int n);
    int w;
    n = 0;
    w = s;
    forever begin
      for (int k = 0; k <= dw; k++) begin
        push_exp(w, 1'b1, 1'b0);
        n++;
      end
      if (w == e) break;
      if (e >= s) w = (st == 0 || w + st >= e) ? e : w + st;
      else        w = (st == 0 || w - st <= e) ? e : w - st;
    end
    push_exp(e, 1'b0, 1'b1);
    n++;
  endtask

  task automatic check_now(input string tag, input exp_t e);
    n_cmp++;
    assert (tuning_word === e.tw) else begin
      n_bad++;
      $error("FAIL %s tuning_word: observed %0h expected %0h", tag, tuning_word, e.tw);
    end
    n_cmp++;
    assert (busy === e.busy) else begin
      n_bad++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, e.busy);
    end
    n_cmp++;
    assert (done === e.done) else begin
      n_bad++;
      $error("FAIL %s done: observed %b expected %b", tag, done, e.done);
    end
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    @(negedge clock);
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_bad++;
      $error("FAIL %s scoreboard: observed empty queue, expected an entry (tw=%0h)", tag, tuning_word);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_now(tag, e);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step_check(tag);
  endtask

  task automatic drive_cfg(input int s, input int e, input int st, input int dw);
    start_word = 16'(s);
    stop_word  = 16'(e);
    step_word  = 16'(st);
    dwell      = 16'(dw);
  endtask

  // Launch: start seen at the next rising edge, dropped after the first check.
  task automatic kick(input int s, input int e, input int st, input int dw, input string tag);
    drive_cfg(s, e, st, dw);
    start = 1'b1;
    step_check(tag);
    start = 1'b0;
  endtask

  task automatic sweep(input int s, input int e, input int st, input int dw, input string tag);
    int n;
    push_sweep(s, e, st, dw, n);
    push_exp(e, 1'b0, 1'b0);
    push_exp(e, 1'b0, 1'b0);
    kick(s, e, st, dw, tag);
    run(n + 1, tag);
  endtask

  initial begin
    int   na;
    int   nb;
    exp_t z;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    drive_cfg(0, 0, 0, 0);
`ifdef NCO_SWEEP_LOOP_EN
    loop = 1'b0;
`endif
    z.tw = 16'h0; z.busy = 1'b0; z.done = 1'b0;
    repeat (2) @(negedge clock);
    check_now("reset", z);
    reset = 1'b0;
    push_exp(0, 1'b0, 1'b0);
    push_exp(0, 1'b0, 1'b0);
    run(2, "idle_after_reset");

    sweep(10, 16, 3, 1, "up_sweep");
    sweep(16, 10, 4, 0, "down_clamp");
    sweep(16'hFFF0, 16'hFFFF, 16'h20, 0, "top_no_wrap");
    sweep(5, 0, 8, 0, "bottom_no_wrap");
    sweep(7, 7, 5, 2, "single_word");
    sweep(3, 9, 0, 1, "zero_step");

    // Abort at cycle 10 with start pulses ignored while busy.
    for (int i = 0; i < 10; i++) push_exp(i / 4, 1'b1, 1'b0);
    kick(0, 100, 1, 3, "abort");
    run(2, "abort");
    drive_cfg(50, 60, 2, 0);
    start = 1'b1;
    run(3, "start_while_busy");
    start = 1'b0;
    run(4, "abort");
    abort = 1'b1;
    start = 1'b1;
    push_exp(2, 1'b0, 1'b0);
    push_exp(2, 1'b0, 1'b0);
    run(2, "abort_hold");
    abort = 1'b0;
    start = 1'b0;
    push_exp(2, 1'b0, 1'b0);
    push_exp(2, 1'b0, 1'b0);
    run(2, "abort_idle");

    // Back-to-back: start held high, accepted in the first IDLE cycle.
    push_sweep(20, 22, 1, 0, na);
    push_exp(22, 1'b0, 1'b0);
    push_sweep(40, 30, 5, 1, nb);
    push_exp(30, 1'b0, 1'b0);
    drive_cfg(20, 22, 1, 0);
    start = 1'b1;
    step_check("b2b_a");
    drive_cfg(40, 30, 5, 1);
    run(na + 1, "b2b_a");
    start = 1'b0;
    run(nb, "b2b_b");

    // Asynchronous reset mid-sweep.
    for (int i = 0; i < 4; i++) push_exp(1000, 1'b1, 1'b0);
    kick(1000, 2000, 1, 5, "pre_reset");
    run(3, "pre_reset");
    #2 reset = 1'b1;
    #1 check_now("async_reset", z);
    @(negedge clock);
    reset = 1'b0;
    push_exp(0, 1'b0, 1'b0);
    run(1, "post_reset");

`ifdef NCO_SWEEP_LOOP_EN
    loop = 1'b1;
    push_exp(1, 1'b1, 1'b0);
    push_exp(2, 1'b1, 1'b0);
    push_exp(3, 1'b1, 1'b0);
    push_exp(1, 1'b1, 1'b1);
    push_exp(2, 1'b1, 1'b0);
    push_exp(3, 1'b1, 1'b0);
    push_exp(1, 1'b1, 1'b1);
    kick(1, 3, 1, 0, "loop");
    run(6, "loop");
    loop = 1'b0;
    push_exp(2, 1'b1, 1'b0);
    push_exp(3, 1'b1, 1'b0);
    push_exp(3, 1'b0, 1'b1);
    push_exp(3, 1'b0, 1'b0);
    run(4, "loop_exit");
`endif

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
